// File: rtl/delta_stress_trend.sv
// Stress-level delta detector: compares each accepted sample with the previous one,
// pulses on real drops/rises, counts stable comparisons and tracks a trend state.
//
//   state   | meaning
//   INIT    | no comparison made since reset (or not yet primed)
//   STEADY  | equal comparisons, or reached stability after a change
//   RISING  | last real change was a rise, not yet stable again
//   FALLING | last real change was a drop, not yet stable again
module delta_stress_trend #(
    parameter int WIDTH      = 3,
    parameter int MIN_DELTA  = 1,
    parameter int STABLE_LEN = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] status,
    output logic             gedaald,
    output logic             gestegen,
    output logic             gelijk,
    output logic [CNT_W-1:0] stable_cnt,
    output logic [1:0]       trend
);

    typedef enum logic [1:0] {
        INIT    = 2'b00,
        STEADY  = 2'b01,
        RISING  = 2'b10,
        FALLING = 2'b11
    } trend_t;

    localparam logic signed [WIDTH:0] MIN_D      = (WIDTH+1)'(MIN_DELTA);
    localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]      STABLE_THR = CNT_W'(STABLE_LEN);

    trend_t                state, state_next;
    logic [WIDTH-1:0]      prev;
    logic                  primed;
    logic signed [WIDTH:0] delta;
    logic                  compare, is_rise, is_drop;
    logic [CNT_W-1:0]      cnt_next;
    logic                  gelijk_next;

    // One extra bit keeps the difference signed so 0 -> max never wraps.
    always_comb begin
        delta   = $signed({1'b0, status}) - $signed({1'b0, prev});
        compare = sample_valid & primed;
        is_rise = compare && (delta >= MIN_D);
        is_drop = compare && (delta <= -MIN_D);
        if (is_rise || is_drop)
            cnt_next = '0;
        else if (stable_cnt == CNT_MAX)
            cnt_next = CNT_MAX;
        else
            cnt_next = stable_cnt + CNT_W'(1);
        gelijk_next = (cnt_next >= STABLE_THR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev       <= '0;
            primed     <= 1'b0;
            gedaald    <= 1'b0;
            gestegen   <= 1'b0;
            stable_cnt <= '0;
            gelijk     <= 1'b0;
        end else begin
            gedaald  <= is_drop;
            gestegen <= is_rise;
            if (sample_valid) begin
                prev   <= status;
                primed <= 1'b1;
            end
            if (compare) begin
                stable_cnt <= cnt_next;
                gelijk     <= gelijk_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= INIT;
        else
            state <= state_next;
    end

    // A change always wins; after a change only reaching stability returns to STEADY.
    always_comb begin
        state_next = state;
        if (is_rise)
            state_next = RISING;
        else if (is_drop)
            state_next = FALLING;
        else if (compare) begin
            case (state)
                INIT, STEADY: state_next = STEADY;
                default:      if (gelijk_next) state_next = STEADY;
            endcase
        end
    end

    always_comb begin
        trend = state;
    end

endmodule

// File: tb/tb_delta_stress_trend.sv
// Scoreboard bench: instance A uses default parameters, instance B uses WIDTH=8,
// MIN_DELTA=2, STABLE_LEN=3, CNT_W=3. Expected outputs come from an arithmetic model.
module tb_delta_stress_trend;

    typedef struct {
        bit ged;
        bit ges;
        bit gel;
        int cnt;
        int trend;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       va, vb;
    logic [2:0] sa;
    logic [7:0] sb;
    logic       ged_a, ges_a, gel_a, ged_b, ges_b, gel_b;
    logic [3:0] cnt_a;
    logic [2:0] cnt_b;
    logic [1:0] trend_a, trend_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    int m_prev[2];
    int m_cnt[2];
    int m_trend[2];
    bit m_primed[2];
    int mind[2] = '{1, 2};
    int slen[2] = '{2, 3};
    int cmax[2] = '{15, 7};

    delta_stress_trend u_a (
        .clk(clk), .reset(reset), .sample_valid(va), .status(sa),
        .gedaald(ged_a), .gestegen(ges_a), .gelijk(gel_a),
        .stable_cnt(cnt_a), .trend(trend_a)
    );

    delta_stress_trend #(.WIDTH(8), .MIN_DELTA(2), .STABLE_LEN(3), .CNT_W(3)) u_b (
        .clk(clk), .reset(reset), .sample_valid(vb), .status(sb),
        .gedaald(ged_b), .gestegen(ges_b), .gelijk(gel_b),
        .stable_cnt(cnt_b), .trend(trend_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_step(input int k, input bit v, input int s);
        exp_t e;
        int   d;
        e.ged = 0;
        e.ges = 0;
        if (v) begin
            if (!m_primed[k]) begin
                m_primed[k] = 1;
            end else begin
                d = s - m_prev[k];
                if (d >= mind[k]) begin
                    e.ges = 1; m_cnt[k] = 0; m_trend[k] = 2;
                end else if (d <= -mind[k]) begin
                    e.ged = 1; m_cnt[k] = 0; m_trend[k] = 3;
                end else begin
                    m_cnt[k] = (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : cmax[k];
                    if (m_trend[k] == 0 || m_cnt[k] >= slen[k]) m_trend[k] = 1;
                end
            end
            m_prev[k] = s;
        end
        e.cnt   = m_cnt[k];
        e.gel   = (m_cnt[k] >= slen[k]);
        e.trend = m_trend[k];
        return e;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prev[k] = 0; m_cnt[k] = 0; m_trend[k] = 0; m_primed[k] = 0;
        end
    endfunction

    task automatic step(input bit v0, input int s0, input bit v1, input int s1);
        @(negedge clk);
        va = v0; sa = 3'(s0); vb = v1; sb = 8'(s1);
        q_a.push_back(model_step(0, v0, s0));
        q_b.push_back(model_step(1, v1, s1));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock.
    task automatic do_reset();
        @(posedge clk);
        #4;
        reset = 1'b0; va = 1'b0; vb = 1'b0;
        #1;
        check("rst_ged_a", ged_a, 0);   check("rst_ges_a", ges_a, 0);
        check("rst_gel_a", gel_a, 0);   check("rst_cnt_a", cnt_a, 0);
        check("rst_trend_a", trend_a, 0);
        check("rst_ged_b", ged_b, 0);   check("rst_ges_b", ges_b, 0);
        check("rst_gel_b", gel_b, 0);   check("rst_cnt_b", cnt_b, 0);
        check("rst_trend_b", trend_b, 0);
        model_reset();
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("ged_a", ged_a, e.ged);   check("ges_a", ges_a, e.ges);
                check("gel_a", gel_a, e.gel);   check("cnt_a", cnt_a, e.cnt);
                check("trend_a", trend_a, e.trend);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("ged_b", ged_b, e.ged);   check("ges_b", ges_b, e.ges);
                check("gel_b", gel_b, e.gel);   check("cnt_b", cnt_b, e.cnt);
                check("trend_b", trend_b, e.trend);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int last_a, last_b, nb;
        reset = 1'b1; va = 1'b0; vb = 1'b0; sa = '0; sb = '0;
        model_reset();
        do_reset();

        // A: 5,5,5 then 6,4,4,4 ; B: 3,4,5,7 with MIN_DELTA=2
        step(1, 5, 1, 3);
        step(1, 5, 1, 4);
        step(1, 5, 1, 5);
        step(1, 6, 1, 7);
        step(1, 4, 1, 255);
        step(1, 4, 1, 255);
        step(1, 4, 1, 255);
        // A: gap sequence ; B: keeps equal comparisons towards saturation
        step(1, 2, 1, 255);
        for (int i = 0; i < 3; i++) step(0, 7, 1, 255);
        step(1, 2, 1, 255);
        for (int i = 0; i < 3; i++) step(0, 2, 1, 255);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Reset mid-run while FALLING with gelijk=0, then re-prime only
        step(1, 6, 0, 0);
        step(1, 4, 0, 0);
        do_reset();
        step(1, 3, 1, 9);
        step(0, 3, 0, 9);
        step(1, 0, 1, 0);
        step(1, 7, 1, 255);

        last_a = 7;
        last_b = 255;
        for (int i = 0; i < 300; i++) begin
            int a_val, b_val;
            bit a_v, b_v;
            if (i == 150) do_reset();
            a_v = ($urandom_range(0, 3) != 0);
            b_v = ($urandom_range(0, 3) != 0);
            a_val = ($urandom_range(0, 1) == 1) ? last_a : int'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                b_val = ($urandom_range(0, 1) == 1) ? 255 : 0;
            end else begin
                nb = last_b + int'($urandom_range(0, 6)) - 3;
                b_val = (nb < 0) ? 0 : (nb > 255) ? 255 : nb;
            end
            step(a_v, a_val, b_v, b_val);
            if (a_v) last_a = a_val;
            if (b_v) last_b = b_val;
        end

        step(0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
